// File: rtl/prog_mem_controller.sv
// prog_mem_controller: round-robin arbiter between NUM_CONSUMERS instruction
// fetchers and a single program-memory read port.
//
// Handshakes:
//   - Fetcher side: a fetcher raises consumer_read_valid[i] with a stable
//     address and holds both until it sees consumer_read_ack[i].
//     The ack is a single-cycle pulse. consumer_read_data[i] is valid from
//     that cycle on and holds until the next ack to the same fetcher.
//   - Memory side: mem_read_valid/mem_read_addr stay steady while a request
//     is outstanding. The first cycle with mem_read_ready high completes it,
//     and mem_read_data is sampled in that cycle.
//
// Only one memory request is outstanding at a time.
// The sequence is IDLE -> MEM_WAIT -> RESPOND -> IDLE.
module prog_mem_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_WIDTH    = 6,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0]  consumer_read_addr,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ack,
  output logic [NUM_CONSUMERS*DATA_WIDTH-1:0]  consumer_read_data,
  output logic                                 mem_read_valid,
  output logic [ADDR_WIDTH-1:0]                mem_read_addr,
  input  logic                                 mem_read_ready,
  input  logic [DATA_WIDTH-1:0]                mem_read_data
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    RESPOND  = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant;

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  logic [ADDR_WIDTH-1:0] grant_addr;

  // Round-robin search: begin just after last_grant and wrap around.
  // The first pending fetcher found wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_CONSUMERS);
      if (!grant_found && consumer_read_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Select the winning fetcher's address. It is captured only at grant time.
  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_addr = consumer_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Controller FSM. All outputs are registered here.
  // Reset abandons any in-flight request without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      last_grant         <= IDX_W'(NUM_CONSUMERS - 1);
      grant              <= '0;
      mem_read_valid     <= 1'b0;
      mem_read_addr      <= '0;
      consumer_read_ack  <= '0;
      consumer_read_data <= '0;
    end else begin
      consumer_read_ack <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            grant          <= grant_idx;
            last_grant     <= grant_idx;
            mem_read_valid <= 1'b1;
            mem_read_addr  <= grant_addr;
            state          <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_read_ready) begin
            mem_read_valid <= 1'b0;
            mem_read_addr  <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
              consumer_read_ack[i] <= (grant == IDX_W'(i));
              if (grant == IDX_W'(i)) begin
                consumer_read_data[i*DATA_WIDTH +: DATA_WIDTH] <= mem_read_data;
              end
            end
            state <= RESPOND;
          end
        end
        RESPOND: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/prog_mem_controller.md
# prog_mem_controller

Program-memory read responder that serves instruction-fetch requests from `NUM_CONSUMERS` fetchers. It sits between the per-core fetchers and the single program-memory read port. Pending requests are granted one at a time in round-robin order. Each granted request is forwarded to memory, and the returned instruction goes back to the requesting fetcher with a one-cycle ack pulse.

## Interface
- `NUM_CONSUMERS`, 4, number of fetchers served (≥1)
- `ADDR_WIDTH`, 6, program-memory address width
- `DATA_WIDTH`, 32, instruction width
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `consumer_read_valid`  in  NUM_CONSUMERS  per-fetcher request; bit i belongs to fetcher i
- `consumer_read_addr`  in  NUM_CONSUMERS*ADDR_WIDTH  packed addresses; fetcher i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `consumer_read_ack`  out  NUM_CONSUMERS  one-cycle completion pulse per fetcher
- `consumer_read_data`  out  NUM_CONSUMERS*DATA_WIDTH  packed returned instructions; fetcher i at [i*DATA_WIDTH +: DATA_WIDTH]
- `mem_read_valid`  out  1  request to program memory
- `mem_read_addr`  out  ADDR_WIDTH  address to program memory
- `mem_read_ready`  in  1  memory has `mem_read_data` valid this cycle
- `mem_read_data`  in  DATA_WIDTH  instruction from memory

## Operation
- **Consumer protocol**
  - A fetcher raises `valid` with a stable address and holds both until it sees ack.
  - It deasserts `valid` on the same edge at which it samples ack high.
  - Any `valid` still high in the IDLE cycle after the ack counts as a new request.
- **States**
  - IDLE: if any `consumer_read_valid` bit is set, grant one fetcher. Latch the grant index `g`. Drive `mem_read_valid<=1` and `mem_read_addr<=addr[g]`. Go to MEM_WAIT. If no bit is set, stay in IDLE.
  - MEM_WAIT: hold `mem_read_valid` and `mem_read_addr`. When `mem_read_ready` is high:
    - `mem_read_valid<=0`, `mem_read_addr<=0`
    - `consumer_read_data[g]<=mem_read_data`
    - `consumer_read_ack[g]<=1`
    - go to RESPOND
  - RESPOND: `consumer_read_ack<=0`, go to IDLE.
- **Round-robin arbitration**
  - Register `last_grant` resets to NUM_CONSUMERS-1.
  - Search starts at `(last_grant+1) mod NUM_CONSUMERS`, ascending with wrap-around.
  - The first set bit wins, and `last_grant<=g`.
- **Address capture**: the address is captured only at grant. Later changes on `consumer_read_addr` do not affect an outstanding request.
- **Data retention**: `consumer_read_data` slice i changes only on an ack to fetcher i and holds its value otherwise. Slices of other fetchers are never disturbed.
- **Single outstanding request**: at most one memory request is outstanding. Requests arriving during MEM_WAIT or RESPOND wait. No request is dropped.
- **Ack properties**: at most one `consumer_read_ack` bit is high in any cycle, and it is high for exactly one cycle.
- **Ignored inputs**: `mem_read_ready` is ignored in IDLE and RESPOND.
- **Reset values**
  - State IDLE
  - `last_grant`=NUM_CONSUMERS-1
  - `mem_read_valid`=0, `mem_read_addr`=0
  - all `consumer_read_ack`=0, all `consumer_read_data`=0
- **Reset mid-operation**: the in-flight request is abandoned with no ack, and the fetcher must re-request. Reset has priority over all other events in the same cycle.

## Timing
- **Minimum latency** (memory ready in its first valid cycle): request visible in cycle 0, `mem_read_valid` high in cycle 1, ack and data in cycle 2, back to IDLE in cycle 3.
- **Memory stalls**: each cycle of `mem_read_ready` low in MEM_WAIT adds exactly one cycle to the ack.
- **Throughput**: maximum one completed request per 3 cycles.
- **Back-to-back requests**: a second pending fetcher is granted in the IDLE cycle immediately after RESPOND, with no idle gap.
- **Data/ack alignment**: `consumer_read_data[g]` is valid in the ack cycle and every cycle after it until the next ack to g.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Single request**: fetcher 1 requests addr 0x05, memory returns 0xDEADBEEF with ready in the first cycle.
  - Expect `mem_read_addr`=0x05 in cycle 1.
  - Expect `consumer_read_ack`=4'b0010 in cycle 2 only.
  - Expect slice 1 = 0xDEADBEEF held afterwards.
- **Simultaneous**: all 4 fetchers request at once after reset, with addresses 0x10–0x13. Expect grants in order 0,1,2,3, acks 3 cycles apart, each slice holding its own data.
- **Fairness**: last grant is 2 and fetchers 1 and 3 are both pending. Expect 3 granted before 1; fetcher 0 joining meanwhile is served after 3 and before 1.
- **Memory stall**: ready is held low for 5 cycles in MEM_WAIT. Expect ack in cycle 7, `mem_read_valid`/`mem_read_addr` stable through the stall, and no ack during the stall.
- **Reset mid-MEM_WAIT**: assert `rst` for 1 cycle.
  - Expect all outputs 0 the next cycle and no ack for the abandoned request.
  - A re-request from fetcher 0 is then granted first.
- **Address change after grant**: change fetcher 2's address during MEM_WAIT. Expect `mem_read_addr` to keep the original value.
